// File: rtl/bc_guess_entry.sv
// bc_guess_entry
//   Player-side front end for the bulls-and-cows core. Buffers four BCD digits,
//   validates them (range, optional uniqueness), hands the guess to the core
//   with a confirm strobe and latches the bulls/cows result for display.
//   Used unchanged for both secret entry and guess entry.
//
// Ports
//   clock        system clock, rising edge
//   reset        asynchronous active-low reset
//   digit_in     digit value from switches
//   digit_load   pulse: append digit_in to the buffer
//   enter        pulse: submit the buffer
//   clear        pulse: empty the buffer and abort
//   core_ready   core can accept a guess/secret
//   result_valid pulse: bulls_in/cows_in are valid
//   bulls_in     bulls from the core (0..4)
//   cows_in      cows from the core (0..4)
//   guess        {d3,d2,d1,d0}, first-entered digit in [15:12]
//   confirm      submission strobe to the core
//   digit_count  digits buffered (0..4)
//   busy         high in CHECK, SEND and WAIT
//   err          0 none, 1 bad digit, 2 incomplete, 3 duplicate, 4 timeout
//   bulls, cows  latched result
//   win          latched bulls==4
module bc_guess_entry #(
  parameter int CONFIRM_CYCLES = 1,
  parameter int TIMEOUT        = 255,
  parameter int UNIQUE_DIGITS  = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  digit_in,
  input  logic        digit_load,
  input  logic        enter,
  input  logic        clear,
  input  logic        core_ready,
  input  logic        result_valid,
  input  logic [2:0]  bulls_in,
  input  logic [2:0]  cows_in,
  output logic [15:0] guess,
  output logic        confirm,
  output logic [2:0]  digit_count,
  output logic        busy,
  output logic [2:0]  err,
  output logic [2:0]  bulls,
  output logic [2:0]  cows,
  output logic        win
);

  typedef enum logic [2:0] {ENTRY, CHECK, SEND, WAIT, DONE} state_t;

  localparam logic [3:0]  CC_LAST = 4'(CONFIRM_CYCLES);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  localparam logic [2:0] ERR_NONE = 3'd0;
  localparam logic [2:0] ERR_BAD  = 3'd1;
  localparam logic [2:0] ERR_INC  = 3'd2;
  localparam logic [2:0] ERR_DUP  = 3'd3;
  localparam logic [2:0] ERR_TO   = 3'd4;

  state_t      state, state_nxt;
  logic [15:0] guess_nxt;
  logic        confirm_nxt;
  logic [2:0]  count_nxt;
  logic        busy_nxt;
  logic [2:0]  err_nxt;
  logic [2:0]  bulls_nxt, cows_nxt;
  logic        win_nxt;
  logic [3:0]  ccnt, ccnt_nxt;   // confirm cycles already issued
  logic [15:0] tcnt, tcnt_nxt;   // cycles spent in WAIT

  // Any pair of the four nibbles equal.
  function automatic logic has_dup(input logic [15:0] g);
    return (g[15:12] == g[11:8]) || (g[15:12] == g[7:4]) || (g[15:12] == g[3:0]) ||
           (g[11:8]  == g[7:4])  || (g[11:8]  == g[3:0]) || (g[7:4]   == g[3:0]);
  endfunction

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= ENTRY;
      guess       <= '0;
      confirm     <= 1'b0;
      digit_count <= '0;
      busy        <= 1'b0;
      err         <= ERR_NONE;
      bulls       <= '0;
      cows        <= '0;
      win         <= 1'b0;
      ccnt        <= '0;
      tcnt        <= '0;
    end else begin
      state       <= state_nxt;
      guess       <= guess_nxt;
      confirm     <= confirm_nxt;
      digit_count <= count_nxt;
      busy        <= busy_nxt;
      err         <= err_nxt;
      bulls       <= bulls_nxt;
      cows        <= cows_nxt;
      win         <= win_nxt;
      ccnt        <= ccnt_nxt;
      tcnt        <= tcnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    guess_nxt   = guess;
    confirm_nxt = 1'b0;
    count_nxt   = digit_count;
    err_nxt     = err;
    bulls_nxt   = bulls;
    cows_nxt    = cows;
    win_nxt     = win;
    ccnt_nxt    = ccnt;
    tcnt_nxt    = tcnt;

    if (clear) begin
      // clear beats every other input in every state
      state_nxt = ENTRY;
      guess_nxt = '0;
      count_nxt = '0;
      err_nxt   = ERR_NONE;
      ccnt_nxt  = '0;
      tcnt_nxt  = '0;
      if (state == DONE) begin
        bulls_nxt = '0;
        cows_nxt  = '0;
        win_nxt   = 1'b0;
      end
    end else begin
      case (state)
        ENTRY: begin
          if (enter) begin
            if (digit_count == 3'd4) begin
              state_nxt = CHECK;
              err_nxt   = ERR_NONE;
            end else begin
              err_nxt = ERR_INC;
            end
          end else if (digit_load) begin
            // a full buffer swallows further digits without complaint
            if (digit_count != 3'd4) begin
              if (digit_in > 4'd9) begin
                err_nxt = ERR_BAD;
              end else begin
                guess_nxt = {guess[11:0], digit_in};
                count_nxt = digit_count + 3'd1;
                err_nxt   = ERR_NONE;
              end
            end
          end
        end
        CHECK: begin
          if ((UNIQUE_DIGITS != 0) && has_dup(guess)) begin
            err_nxt   = ERR_DUP;
            guess_nxt = '0;
            count_nxt = '0;
            state_nxt = ENTRY;
          end else begin
            ccnt_nxt  = '0;
            state_nxt = SEND;
          end
        end
        SEND: begin
          // once started, the strobe runs its full length regardless of core_ready
          if (confirm) begin
            if (ccnt == CC_LAST) begin
              state_nxt = WAIT;
              tcnt_nxt  = '0;
            end else begin
              confirm_nxt = 1'b1;
              ccnt_nxt    = ccnt + 4'd1;
            end
          end else if (core_ready) begin
            confirm_nxt = 1'b1;
            ccnt_nxt    = 4'd1;
          end
        end
        WAIT: begin
          // a result arriving on the last allowed cycle still wins over timeout
          if (result_valid) begin
            bulls_nxt = bulls_in;
            cows_nxt  = cows_in;
            win_nxt   = (bulls_in == 3'd4);
            guess_nxt = '0;
            count_nxt = '0;
            state_nxt = (bulls_in == 3'd4) ? DONE : ENTRY;
          end else if (tcnt == TO_LAST) begin
            err_nxt   = ERR_TO;
            guess_nxt = '0;
            count_nxt = '0;
            state_nxt = ENTRY;
          end else begin
            tcnt_nxt = tcnt + 16'd1;
          end
        end
        DONE: begin
          state_nxt = DONE;
        end
        default: begin
          state_nxt = ENTRY;
        end
      endcase
    end

    busy_nxt = (state_nxt == CHECK) || (state_nxt == SEND) || (state_nxt == WAIT);
  end

endmodule

// File: tb/tb_bc_guess_entry.sv
module tb_bc_guess_entry;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  digit_in = '0;
  logic        digit_load = 1'b0;
  logic        enter = 1'b0;
  logic        clear = 1'b0;
  logic        core_ready = 1'b0;
  logic        result_valid = 1'b0;
  logic [2:0]  bulls_in = '0;
  logic [2:0]  cows_in = '0;

  logic [15:0] guess, guess3;
  logic        confirm, confirm3;
  logic [2:0]  digit_count, digit_count3;
  logic        busy, busy3;
  logic [2:0]  err, err3;
  logic [2:0]  bulls, bulls3, cows, cows3;
  logic        win, win3;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] exp_guess_q[$];
  logic [6:0]  exp_res_q[$];   // {bulls, cows, win}

  always #5 clock = ~clock;

  bc_guess_entry #(.CONFIRM_CYCLES(1), .TIMEOUT(8), .UNIQUE_DIGITS(1)) dut (
    .clock(clock), .reset(reset), .digit_in(digit_in), .digit_load(digit_load),
    .enter(enter), .clear(clear), .core_ready(core_ready), .result_valid(result_valid),
    .bulls_in(bulls_in), .cows_in(cows_in), .guess(guess), .confirm(confirm),
    .digit_count(digit_count), .busy(busy), .err(err), .bulls(bulls), .cows(cows),
    .win(win)
  );

  bc_guess_entry #(.CONFIRM_CYCLES(3), .TIMEOUT(8), .UNIQUE_DIGITS(1)) dut3 (
    .clock(clock), .reset(reset), .digit_in(digit_in), .digit_load(digit_load),
    .enter(enter), .clear(clear), .core_ready(core_ready), .result_valid(result_valid),
    .bulls_in(bulls_in), .cows_in(cows_in), .guess(guess3), .confirm(confirm3),
    .digit_count(digit_count3), .busy(busy3), .err(err3), .bulls(bulls3), .cows(cows3),
    .win(win3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load(input logic [3:0] d);
    digit_in   = d;
    digit_load = 1'b1;
    tick();
    digit_load = 1'b0;
  endtask

  task automatic load4(input logic [15:0] g);
    for (int i = 3; i >= 0; i--) load(g[4*i +: 4]);
  endtask

  task automatic pulse_enter();
    enter = 1'b1;
    tick();
    enter = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic wait_confirm(input int budget, output int lat);
    lat = 0;
    while (confirm !== 1'b1 && lat < budget) begin
      tick();
      lat++;
    end
    chk("confirm_rise", 32'(confirm), 32'd1);
    if (exp_guess_q.size() > 0) chk("sent_guess", 32'(guess), 32'(exp_guess_q.pop_front()));
  endtask

  task automatic send_result(input logic [2:0] b, input logic [2:0] c);
    bulls_in     = b;
    cows_in      = c;
    result_valid = 1'b1;
    exp_res_q.push_back({b, c, (b == 3'd4)});
    tick();
    result_valid = 1'b0;
    if (exp_res_q.size() > 0) chk("result", 32'({bulls, cows, win}), 32'(exp_res_q.pop_front()));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int lat, n, h1, h3, first3, last3;

    // reset state
    #3 reset = 1'b0;
    tick();
    tick();
    chk("rst_guess", 32'(guess), 32'h0);
    chk("rst_count", 32'(digit_count), 32'h0);
    chk("rst_ctl", 32'({confirm, busy, err}), 32'h0);
    chk("rst_result", 32'({bulls, cows, win}), 32'h0);
    reset = 1'b1;

    // basic submit and non-winning result
    load4(16'h1234);
    chk("load_guess", 32'(guess), 32'h1234);
    chk("load_count", 32'(digit_count), 32'd4);
    core_ready = 1'b1;
    exp_guess_q.push_back(16'h1234);
    pulse_enter();
    chk("check_busy", 32'(busy), 32'd1);
    chk("check_no_confirm", 32'(confirm), 32'd0);
    wait_confirm(10, lat);
    chk("confirm_latency", 32'(lat), 32'd2);
    tick();
    chk("confirm_width1", 32'(confirm), 32'd0);
    chk("wait_busy", 32'(busy), 32'd1);
    send_result(3'd1, 3'd2);
    chk("res_count", 32'(digit_count), 32'd0);
    chk("res_guess", 32'(guess), 32'h0);
    chk("res_busy", 32'(busy), 32'd0);
    bulls_in = 3'd3;
    result_valid = 1'b1;
    tick();
    result_valid = 1'b0;
    chk("rv_ignored", 32'(bulls), 32'd1);
    pulse_clear();
    chk("clear_keeps_bulls", 32'({bulls, cows}), 32'({3'd1, 3'd2}));

    // duplicate reject, bad digit, incomplete, full buffer, priority
    load4(16'h5567);
    pulse_enter();
    chk("dup_busy", 32'(busy), 32'd1);
    tick();
    chk("dup_err", 32'(err), 32'd3);
    chk("dup_guess", 32'(guess), 32'h0);
    chk("dup_count", 32'(digit_count), 32'd0);
    chk("dup_idle", 32'({busy, confirm}), 32'd0);
    load(4'h8);
    load(4'hA);
    chk("bad_err", 32'(err), 32'd1);
    chk("bad_count", 32'(digit_count), 32'd1);
    chk("bad_guess", 32'(guess), 32'h0008);
    load(4'h9);
    chk("bad_cleared", 32'(err), 32'd0);
    pulse_enter();
    chk("inc_err", 32'(err), 32'd2);
    chk("inc_busy", 32'(busy), 32'd0);
    load(4'h0);
    load(4'h1);
    load(4'h2);
    chk("full_guess", 32'(guess), 32'h8901);
    chk("full_count", 32'(digit_count), 32'd4);
    enter = 1'b1;
    clear = 1'b1;
    tick();
    enter = 1'b0;
    clear = 1'b0;
    chk("prio_count", 32'(digit_count), 32'd0);
    chk("prio_busy", 32'(busy), 32'd0);

    // core not ready, then timeout
    core_ready = 1'b0;
    load4(16'h9876);
    exp_guess_q.push_back(16'h9876);
    pulse_enter();
    h1 = 0;
    repeat (10) begin
      tick();
      h1 += int'(confirm);
    end
    chk("notready_confirm", 32'(h1), 32'd0);
    chk("notready_busy", 32'(busy), 32'd1);
    core_ready = 1'b1;
    wait_confirm(5, lat);
    chk("ready_latency", 32'(lat), 32'd1);
    tick();
    chk("ready_width", 32'(confirm), 32'd0);
    n = 0;
    while (err !== 3'd4 && n < 20) begin
      tick();
      n++;
    end
    chk("timeout_cycles", 32'(n), 32'd8);
    chk("timeout_clr", 32'({guess, digit_count, busy}), 32'h0);
    pulse_clear();

    // result on the last WAIT cycle counts as a result
    load4(16'h0123);
    exp_guess_q.push_back(16'h0123);
    pulse_enter();
    wait_confirm(10, lat);
    tick();
    repeat (7) tick();
    send_result(3'd0, 3'd3);
    chk("edge_err", 32'(err), 32'd0);
    pulse_clear();

    // win and DONE behaviour
    load4(16'h4321);
    exp_guess_q.push_back(16'h4321);
    pulse_enter();
    wait_confirm(10, lat);
    tick();
    send_result(3'd4, 3'd0);
    chk("win_busy", 32'(busy), 32'd0);
    load(4'h5);
    chk("done_load", 32'({guess, digit_count}), 32'h0);
    pulse_enter();
    chk("done_enter", 32'({busy, err}), 32'h0);
    bulls_in = 3'd2;
    result_valid = 1'b1;
    tick();
    result_valid = 1'b0;
    chk("done_rv", 32'({bulls, win}), 32'({3'd4, 1'b1}));
    pulse_clear();
    chk("done_clear", 32'({bulls, cows, win}), 32'h0);

    // CONFIRM_CYCLES=3 instance
    load4(16'h1357);
    pulse_enter();
    h1 = 0; h3 = 0; first3 = 0; last3 = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (confirm3 === 1'b1) begin
        if (first3 == 0) first3 = k;
        last3 = k;
      end
      h1 += int'(confirm);
      h3 += int'(confirm3);
    end
    chk("c3_count", 32'(h3), 32'd3);
    chk("c3_first", 32'(first3), 32'd2);
    chk("c3_last", 32'(last3), 32'd4);
    chk("c1_count", 32'(h1), 32'd1);
    pulse_clear();

    // clear truncates confirm
    load4(16'h2468);
    pulse_enter();
    tick();
    tick();
    chk("trunc_pre", 32'(confirm3), 32'd1);
    pulse_clear();
    chk("trunc_confirm", 32'({confirm3, busy3}), 32'h0);
    chk("trunc_guess", 32'(guess3), 32'h0);

    // asynchronous reset during SEND
    load4(16'h1470);
    pulse_enter();
    tick();
    tick();
    chk("arst_pre", 32'({confirm, busy}), 32'h3);
    #2 reset = 1'b0;
    #1;
    chk("arst_ctl", 32'({confirm, busy, confirm3, busy3}), 32'h0);
    chk("arst_guess", 32'(guess), 32'h0);
    tick();
    reset = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bc_guess_entry.md
Name: bc_guess_entry

Overview:
- Player-side front end for the bulls-and-cows core; it drives the core's guess/confirm inputs and consumes its bulls/cows result.
- Collects four BCD digits from switch/button inputs and validates them: digits must be 0-9 and, optionally, not repeated.
- Presents the validated guess, issues a confirm pulse once the core is ready, and latches the returned bulls/cows for display.
- The same block is used for both the secret-entry and guess-entry phases.

Parameters:
- CONFIRM_CYCLES, 1: number of cycles confirm is held high per submission (1..15).
- TIMEOUT, 255: cycles to wait for result_valid before reporting a timeout (1..65535).
- UNIQUE_DIGITS, 1: when 1, a guess containing a repeated digit is rejected.

Ports:
- clock in 1: system clock; all state updates on the rising edge.
- reset in 1: asynchronous, active-low reset.
- digit_in in 4: digit value from switches.
- digit_load in 1: single-cycle pulse; append digit_in.
- enter in 1: single-cycle pulse; submit the buffer.
- clear in 1: single-cycle pulse; empty the buffer and abort.
- core_ready in 1: core can accept a guess/secret.
- result_valid in 1: single-cycle pulse; bulls_in/cows_in are valid.
- bulls_in in 3: bulls from the core (0..4).
- cows_in in 3: cows from the core (0..4).
- guess out 16: {d3,d2,d1,d0}; the first-entered digit sits in [15:12] once four digits are loaded.
- confirm out 1: submission strobe to the core.
- digit_count out 3: digits currently buffered (0..4).
- busy out 1: high in CHECK, SEND and WAIT.
- err out 3: 0 none, 1 bad digit, 2 incomplete, 3 duplicate, 4 timeout.
- bulls out 3: latched result.
- cows out 3: latched result.
- win out 1: latched bulls==4.

Behaviour:
- Reset (reset=0, asynchronous): state=ENTRY; guess, digit_count, confirm, busy, err, bulls, cows and win all 0; internal counters cleared.
- States: ENTRY, CHECK, SEND, WAIT, DONE. All outputs are registered.
- Input priority in ENTRY when pulses coincide: clear > enter > digit_load.
- ENTRY, digit_load with digit_in<=9 and digit_count<4:
  - guess <= {guess[11:0], digit_in}; digit_count += 1; err <= 0.
- ENTRY, digit_load with digit_in>9: buffer unchanged; err <= 1.
- ENTRY, digit_load with digit_count==4: ignored silently; buffer and err unchanged.
- ENTRY, enter with digit_count<4: err <= 2; stay in ENTRY.
- ENTRY, enter with digit_count==4: go to CHECK; err <= 0.
- CHECK, exactly 1 cycle:
  - If UNIQUE_DIGITS=1 and any two of the four nibbles are equal: err <= 3; guess <= 0; digit_count <= 0; go to ENTRY.
  - Otherwise go to SEND.
- SEND:
  - guess holds stable.
  - While core_ready=0, wait with confirm=0.
  - Once core_ready=1 is sampled, confirm=1 for exactly CONFIRM_CYCLES consecutive cycles, starting the cycle after sampling, regardless of later core_ready. Then go to WAIT.
- WAIT:
  - The timeout counter starts at 0 on entry and increments each cycle.
  - On result_valid: bulls <= bulls_in; cows <= cows_in; win <= (bulls_in==4); guess <= 0; digit_count <= 0. Go to DONE if bulls_in==4, else to ENTRY.
  - If the counter reaches TIMEOUT before result_valid: err <= 4; buffer cleared; go to ENTRY.
  - result_valid on the same cycle as the TIMEOUT cycle counts as a result, not a timeout.
  - result_valid outside WAIT is ignored.
- DONE: all inputs are ignored except clear.
- clear, any state: guess <= 0; digit_count <= 0; confirm <= 0; err <= 0; go to ENTRY.
  - In DONE, clear additionally zeroes bulls, cows and win.
  - In all other states, bulls and cows keep their last values.
- A clear during SEND truncates confirm immediately (next edge).
- busy = 1 exactly in CHECK, SEND and WAIT.
- guess changes only in ENTRY, CHECK (reject) and on a result/clear/timeout; it never changes while confirm=1.

Test Plan:
- Load 1,2,3,4, enter, core_ready=1 -> guess=16'h1234; confirm high 1 cycle, 2 cycles after enter; busy=1 until the result.
- In WAIT, pulse result_valid with bulls_in=1, cows_in=2 -> bulls=1, cows=2, win=0, digit_count=0, state back to ENTRY.
- Load 5,5,6,7, enter -> err=3, guess=0, confirm never asserted. Load A -> err=1, digit_count unchanged. Enter with 2 digits -> err=2.
- Hold core_ready=0 for 10 cycles after enter -> confirm stays 0; raise core_ready -> single confirm pulse. Rerun with CONFIRM_CYCLES=3 -> 3-cycle pulse.
- TIMEOUT=8 with no result_valid -> err=4 after 8 WAIT cycles. Then submit and return bulls_in=4 -> win=1; digit_load/enter ignored; clear -> win=0, bulls=0.
- Assert reset=0 mid-SEND with confirm=1 -> confirm, guess and busy go to 0 immediately, without waiting for a clock edge.
